// File: rtl/rs232c_pkg.sv
// Shared definitions for the RS232C receive/transmit pair.
package rs232c_pkg;

  localparam int DEFAULT_BIT_CYCLES = 868;
  localparam int FRAME_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop bit synchroniser for asynchronous pins; all stages reset to 1 (idle line level).
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rs232c_rx.sv
// RS232C 8N1 receiver with mid-bit sampling from a cycle counter.
// Define RS232C_RX_PARITY_EN for 8E1 frames with an extra par_err pulse output.
module rs232c_rx
  import rs232c_pkg::*;
#(
  parameter int BIT_CYCLES  = DEFAULT_BIT_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rxd,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] LED
`ifdef RS232C_RX_PARITY_EN
  ,
  output logic       par_err
`endif
);

  localparam logic [15:0] LAST     = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] MID_LAST = 16'(BIT_CYCLES / 2 - 1);

  rx_state_t        state;
  logic [15:0]      cnt;
  logic [2:0]       bitidx;
  logic [7:0]       shreg;
  logic             rxs;
  logic             rxs_d;
  logic [SYNC_STAGES:0] prime;
`ifdef RS232C_RX_PARITY_EN
  logic             par_bad;
`endif

  sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (uart_rxd),
    .q   (rxs),
    .*
  );

  // Edge detection is held off until the synchroniser carries real pin samples,
  // so a line already low at reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      rxs_d     <= 1'b1;
      prime     <= '0;
      rxdata    <= '0;
      LED       <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef RS232C_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      rxs_d     <= rxs;
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RS232C_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (prime[SYNC_STAGES] && rxs_d && !rxs) begin
            cnt   <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == MID_LAST) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt    <= '0;
              bitidx <= '0;
              state  <= DATA;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg  <= {rxs, shreg[7:1]};
            cnt    <= '0;
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) begin
`ifdef RS232C_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef RS232C_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            par_bad <= ^{shreg, rxs};
            cnt     <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
`ifdef RS232C_RX_PARITY_EN
              if (par_bad) begin
                par_err <= 1'b1;
              end else begin
                rxdata   <= shreg;
                LED      <= shreg;
                rx_valid <= 1'b1;
              end
`else
              rxdata   <= shreg;
              LED      <= shreg;
              rx_valid <= 1'b1;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232c_rx.sv
// Directed bench for rs232c_rx: reset, latency, glitch, framing error, skewed back-to-back frames, mid-frame reset.
module tb_rs232c_rx;

  localparam int BC = 868;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] LED;
`ifdef RS232C_RX_PARITY_EN
  logic       par_err;
`endif

  rs232c_rx #(
    .BIT_CYCLES (BC),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .uart_rxd (uart_rxd),
    .rxdata   (rxdata),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy),
    .LED      (LED)
`ifdef RS232C_RX_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;
  int n_perr = 0;
  int t_start = 0;
  int t_valid = 0;
  logic [7:0] q_data[$];
  logic [7:0] q_led[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_valid) begin
        n_valid++;
        t_valid = cyc;
        q_data.push_back(rxdata);
        q_led.push_back(LED);
      end
      if (frame_err) n_ferr++;
      if (rx_valid && frame_err) n_both++;
`ifdef RS232C_RX_PARITY_EN
      if (par_err) n_perr++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    logic [7:0] l;
    if (q_data.size() > 0) begin
      d = q_data.pop_front();
      l = q_led.pop_front();
    end else begin
      d = 'x;
      l = 'x;
    end
    check({tag, "_rxdata"}, {24'd0, d}, {24'd0, exp});
    check({tag, "_led"}, {24'd0, l}, {24'd0, exp});
  endtask

  // Drives one frame; stopv=0 holds the line low for two bit times before releasing.
  task automatic send_frame(input logic [7:0] d, input int per, input logic stopv,
                            input logic bad_par, input int rst_bit);
    uart_rxd = 1'b0;
    t_start  = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == rst_bit) begin
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        repeat (per - 110) @(negedge clk);
      end else begin
        repeat (per) @(negedge clk);
      end
    end
`ifdef RS232C_RX_PARITY_EN
    uart_rxd = (^d) ^ bad_par;
    repeat (per) @(negedge clk);
`else
    if (bad_par) uart_rxd = 1'b1;
`endif
    uart_rxd = stopv;
    repeat (per) @(negedge clk);
    if (!stopv) begin
      repeat (per) @(negedge clk);
      uart_rxd = 1'b1;
    end
  endtask

  int v0;
  int f0;
  int lat;

  initial begin
    uart_rxd = 1'b0;
    rstn     = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rxdata", {24'd0, rxdata}, 32'h00);
    check("rst_led", {24'd0, LED}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    rstn = 1'b1;
    repeat (50) @(negedge clk);
    check("low_at_release_busy", {31'd0, busy}, 32'd0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'hA5, BC, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("a5_valid_cnt", n_valid, 1);
    expect_byte("a5", 8'hA5);
    lat = t_valid - t_start;
    check("a5_latency_in_window", {31'd0, (lat >= 8247 && lat <= 8249)}, 32'd1);
    check("a5_ferr_cnt", n_ferr, 0);

    v0 = n_valid;
    f0 = n_ferr;
    uart_rxd = 1'b0;
    repeat (200) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (160) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    repeat (500) @(negedge clk);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_ferr_cnt", n_ferr - f0, 0);

    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, BC, 1'b0, 1'b0, -1);
    repeat (2 * BC) @(negedge clk);
    check("ferr_pulse_cnt", n_ferr - f0, 1);
    check("ferr_valid_cnt", n_valid - v0, 0);
    check("ferr_rxdata_held", {24'd0, rxdata}, 32'hA5);
    send_frame(8'h81, BC, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("after_ferr_valid_cnt", n_valid - v0, 1);
    expect_byte("after_ferr_81", 8'h81);

    v0 = n_valid;
    send_frame(8'h00, 885, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 851, 1'b1, 1'b0, -1);
    send_frame(8'h55, BC, 1'b1, 1'b0, -1);
    repeat (50) @(negedge clk);
    check("b2b_valid_cnt", n_valid - v0, 3);
    expect_byte("b2b_00", 8'h00);
    expect_byte("b2b_ff", 8'hFF);
    expect_byte("b2b_55", 8'h55);

    v0 = n_valid;
    send_frame(8'hF0, BC, 1'b1, 1'b0, 4);
    repeat (20) @(negedge clk);
    check("midrst_valid_cnt", n_valid - v0, 0);
    check("midrst_rxdata_cleared", {24'd0, rxdata}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h12, BC, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("after_midrst_valid_cnt", n_valid - v0, 1);
    expect_byte("after_midrst_12", 8'h12);

`ifdef RS232C_RX_PARITY_EN
    v0 = n_valid;
    f0 = n_perr;
    send_frame(8'h07, BC, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("par_good_valid_cnt", n_valid - v0, 1);
    expect_byte("par_good_07", 8'h07);
    check("par_good_perr_cnt", n_perr - f0, 0);
    send_frame(8'h07, BC, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("par_bad_perr_cnt", n_perr - f0, 1);
    check("par_bad_valid_cnt", n_valid - v0, 1);
    check("par_bad_rxdata_held", {24'd0, rxdata}, 32'h07);
`endif

    check("valid_ferr_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
